// File: rtl/step_ctrl.sv
// Single-step button controller: synchronizes and debounces the raw step button,
// issues one step_en pulse per clean press and waits for the core's acknowledge.
module step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             next_inst,
    input  logic             inst_done,
    output logic             step_en,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] step_count,
    output logic [2:0]       dbg_state
);

    localparam int MAX_CYC = (DEBOUNCE_CYCLES > TIMEOUT_CYCLES) ? DEBOUNCE_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        STEP      = 3'd2,
        WAIT_DONE = 3'd3,
        WAIT_REL  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_s1;
    logic             r_btn_s;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic             r_fault;
    logic             w_fault_set;
    logic             w_step;
    logic [CNT_W-1:0] r_step_count;

    // Two-flop synchronizer; only r_btn_s is visible to the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_btn_s <= 1'b0;
        end else begin
            r_s1    <= next_inst;
            r_btn_s <= r_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_fault      <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
            if (w_step) begin
                r_step_count <= r_step_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_fault_set  = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_btn_s) begin
                    w_next_state = DEB_PRESS;
                    w_cnt_next   = '0;
                end
            end
            DEB_PRESS: begin
                if (!r_btn_s) begin
                    w_next_state = IDLE;
                end else if (r_cnt == DEB_LAST) begin
                    w_next_state = STEP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            STEP: begin
                // Counter is cleared on both exits so the release count always starts fresh.
                w_step       = 1'b1;
                w_cnt_next   = '0;
                w_next_state = inst_done ? WAIT_REL : WAIT_DONE;
            end
            WAIT_DONE: begin
                if (inst_done) begin
                    w_next_state = WAIT_REL;
                    w_cnt_next   = '0;
                end else if (r_cnt == TO_LAST) begin
                    w_fault_set  = 1'b1;
                    w_next_state = WAIT_REL;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            WAIT_REL: begin
                if (r_btn_s) begin
                    w_cnt_next = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_next_state = IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign step_en    = (r_state == STEP);
    assign busy       = (r_state != IDLE);
    assign fault      = r_fault;
    assign step_count = r_step_count;
    assign dbg_state  = r_state;

endmodule
